de1_soc_alternative_hps_master_st_packet_arbiter: RTL and testbench

Packet-aware round-robin arbiter that merges NUM_IN Avalon-ST packet sources into one channelized Avalon-ST stream. It drives the input side of the HPS master packets-to-bytes channel adapter. Grant is locked from the first accepted beat of a packet through its EOP beat, so packets are never interleaved. out_channel carries the granted source index.

---
 rtl/de1_soc_alternative_hps_master_st_packet_arbiter.sv | 145 ++++++++++++++
 tb/tb_de1_soc_alternative_hps_master_st_packet_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/de1_soc_alternative_hps_master_st_packet_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_IN Avalon-ST sources into one channelized
// stream; the grant is held from the first accepted beat until the EOP beat transfers.
module de1_soc_alternative_hps_master_st_packet_arbiter #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CHANNEL_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN-1:0]          in_valid,
  output logic [NUM_IN-1:0]          in_ready,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN-1:0]          in_startofpacket,
  input  logic [NUM_IN-1:0]          in_endofpacket,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_startofpacket,
  output logic                       out_endofpacket,
  output logic [CHANNEL_W-1:0]       out_channel
);

  localparam int unsigned IdxW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  logic                 state_q, state_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_sop_q, out_sop_d;
  logic                 out_eop_q, out_eop_d;
  logic [CHANNEL_W-1:0] out_channel_q, out_channel_d;

  logic                 pick_found;
  logic [IdxW-1:0]      pick_idx;
  logic                 accept;
  logic                 xfer;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_sop;
  logic                 sel_eop;
  logic [IdxW-1:0]      grant_next;

  // Search rr_ptr, rr_ptr+1, ... modulo NUM_IN for the first valid source.
  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      cand     = (int'(rr_ptr_q) + k) % NUM_IN;
      cand_idx = IdxW'(cand);
      if (!pick_found && in_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign accept     = !out_valid_q || out_ready;
  assign xfer       = (state_q == StBusy) && in_valid[grant_q] && accept;
  assign sel_data   = in_data[int'(grant_q)*DATA_W +: DATA_W];
  assign sel_sop    = in_startofpacket[grant_q];
  assign sel_eop    = in_endofpacket[grant_q];
  assign grant_next = (grant_q == IdxW'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    in_ready = '0;
    if (state_q == StBusy && accept) begin
      in_ready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_channel_d = out_channel_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (xfer) begin
          // A load in the same cycle as a drain keeps out_valid high.
          out_valid_d   = 1'b1;
          out_data_d    = sel_data;
          out_sop_d     = sel_sop;
          out_eop_d     = sel_eop;
          out_channel_d = CHANNEL_W'(grant_q);
          if (sel_eop) begin
            state_d  = StIdle;
            rr_ptr_d = grant_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_channel_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_channel_q <= out_channel_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_channel       = out_channel_q;

endmodule

// File: tb/tb_de1_soc_alternative_hps_master_st_packet_arbiter.sv
// Directed cycle-by-cycle vectors for the packet arbiter; each row drives one cycle of inputs
// and checks in_ready plus the registered output beat visible during that cycle.
module tb_de1_soc_alternative_hps_master_st_packet_arbiter;

  localparam int unsigned NUM_IN    = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CHANNEL_W = 8;

  logic                      clk;
  logic                      reset;
  logic [NUM_IN-1:0]         in_valid;
  logic [NUM_IN-1:0]         in_ready;
  logic [NUM_IN*DATA_W-1:0]  in_data;
  logic [NUM_IN-1:0]         in_startofpacket;
  logic [NUM_IN-1:0]         in_endofpacket;
  logic                      out_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_startofpacket;
  logic                      out_endofpacket;
  logic [CHANNEL_W-1:0]      out_channel;

  de1_soc_alternative_hps_master_st_packet_arbiter #(
    .NUM_IN    (NUM_IN),
    .DATA_W    (DATA_W),
    .CHANNEL_W (CHANNEL_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] dat;
    logic [3:0]  sop;
    logic [3:0]  eop;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_v;
    logic [7:0]  e_d;
    logic        e_s;
    logic        e_e;
    logic [7:0]  e_ch;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input string n, input logic rst, input logic [3:0] iv,
                     input logic [31:0] dat, input logic [3:0] sop, input logic [3:0] eop,
                     input logic ordy, input logic [3:0] e_rdy, input logic e_v,
                     input logic [7:0] e_d, input logic e_s, input logic e_e,
                     input logic [7:0] e_ch);
    vec_t v;
    v.name = n;   v.rst = rst;     v.iv = iv;     v.dat = dat;  v.sop = sop;
    v.eop = eop;  v.ordy = ordy;   v.e_rdy = e_rdy; v.e_v = e_v; v.e_d = e_d;
    v.e_s = e_s;  v.e_e = e_e;     v.e_ch = e_ch;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input int row, input string what,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row %0d %s got %h want %h", n, row, what, got, want);
    end
  endtask

  initial begin
    reset            = 1'b1;
    in_valid         = '0;
    in_data          = '0;
    in_startofpacket = '0;
    in_endofpacket   = '0;
    out_ready        = 1'b1;

    // Single source 3-beat packet, then rr_ptr=1 shown by source 1 beating source 0.
    add("single", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("single", 0, 4'h1, 32'h11,       4'h1, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("single", 0, 4'h1, 32'h11,       4'h1, 4'h0, 1, 4'h1, 0, 8'h00, 0, 0, 8'h0);
    add("single", 0, 4'h1, 32'h22,       4'h0, 4'h0, 1, 4'h1, 1, 8'h11, 1, 0, 8'h0);
    add("single", 0, 4'h1, 32'h33,       4'h0, 4'h1, 1, 4'h1, 1, 8'h22, 0, 0, 8'h0);
    add("single", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 1, 8'h33, 0, 1, 8'h0);
    add("single", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("rrptr",  0, 4'h3, 32'h5150,     4'h3, 4'h3, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("rrptr",  0, 4'h3, 32'h5150,     4'h3, 4'h3, 1, 4'h2, 0, 8'h00, 0, 0, 8'h0);
    add("rrptr",  0, 4'h1, 32'h5150,     4'h3, 4'h3, 1, 4'h0, 1, 8'h51, 1, 1, 8'h1);
    add("rrptr",  0, 4'h1, 32'h5150,     4'h3, 4'h3, 1, 4'h1, 0, 8'h00, 0, 0, 8'h0);
    add("rrptr",  0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 1, 8'h50, 1, 1, 8'h0);
    add("rrptr",  0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    // Contention from reset: sources 1 and 2, 2-beat packets each.
    add("contend", 1, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("contend", 0, 4'h6, 32'h00B1A100, 4'h6, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("contend", 0, 4'h6, 32'h00B1A100, 4'h6, 4'h0, 1, 4'h2, 0, 8'h00, 0, 0, 8'h0);
    add("contend", 0, 4'h6, 32'h00B1A200, 4'h4, 4'h2, 1, 4'h2, 1, 8'hA1, 1, 0, 8'h1);
    add("contend", 0, 4'h4, 32'h00B10000, 4'h4, 4'h0, 1, 4'h0, 1, 8'hA2, 0, 1, 8'h1);
    add("contend", 0, 4'h4, 32'h00B10000, 4'h4, 4'h0, 1, 4'h4, 0, 8'h00, 0, 0, 8'h0);
    add("contend", 0, 4'h4, 32'h00B20000, 4'h0, 4'h4, 1, 4'h4, 1, 8'hB1, 1, 0, 8'h2);
    add("contend", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 1, 8'hB2, 0, 1, 8'h2);
    add("contend", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    // Backpressure: out_ready low for 3 cycles mid-packet on source 3.
    add("bp", 0, 4'h8, 32'hC1000000, 4'h8, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("bp", 0, 4'h8, 32'hC1000000, 4'h8, 4'h0, 1, 4'h8, 0, 8'h00, 0, 0, 8'h0);
    add("bp", 0, 4'h8, 32'hC2000000, 4'h0, 4'h0, 0, 4'h0, 1, 8'hC1, 1, 0, 8'h3);
    add("bp", 0, 4'h8, 32'hC2000000, 4'h0, 4'h0, 0, 4'h0, 1, 8'hC1, 1, 0, 8'h3);
    add("bp", 0, 4'h8, 32'hC2000000, 4'h0, 4'h0, 0, 4'h0, 1, 8'hC1, 1, 0, 8'h3);
    add("bp", 0, 4'h8, 32'hC2000000, 4'h0, 4'h0, 1, 4'h8, 1, 8'hC1, 1, 0, 8'h3);
    add("bp", 0, 4'h8, 32'hC3000000, 4'h0, 4'h8, 1, 4'h8, 1, 8'hC2, 0, 0, 8'h3);
    add("bp", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 1, 8'hC3, 0, 1, 8'h3);
    add("bp", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    // Round-robin wrap with all sources sending single-beat packets.
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h1, 0, 8'h00, 0, 0, 8'h0);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h0, 1, 8'hD0, 1, 1, 8'h0);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h2, 0, 8'h00, 0, 0, 8'h0);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h0, 1, 8'hD1, 1, 1, 8'h1);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h4, 0, 8'h00, 0, 0, 8'h0);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h0, 1, 8'hD2, 1, 1, 8'h2);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h8, 0, 8'h00, 0, 0, 8'h0);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h0, 1, 8'hD3, 1, 1, 8'h3);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h1, 0, 8'h00, 0, 0, 8'h0);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h0, 1, 8'hD0, 1, 1, 8'h0);
    add("wrap", 0, 4'hF, 32'hD3D2D1D0, 4'hF, 4'hF, 1, 4'h2, 0, 8'h00, 0, 0, 8'h0);
    add("wrap", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 1, 8'hD1, 1, 1, 8'h1);
    add("wrap", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    // Reset after beat 2 of source 2's packet; rr_ptr back to 0 so source 0 wins next.
    add("rstmid", 0, 4'h4, 32'h00E10000, 4'h4, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("rstmid", 0, 4'h4, 32'h00E10000, 4'h4, 4'h0, 1, 4'h4, 0, 8'h00, 0, 0, 8'h0);
    add("rstmid", 0, 4'h4, 32'h00E20000, 4'h0, 4'h0, 1, 4'h4, 1, 8'hE1, 1, 0, 8'h2);
    add("rstmid", 1, 4'h4, 32'h00E30000, 4'h0, 4'h0, 1, 4'h4, 1, 8'hE2, 0, 0, 8'h2);
    add("rstmid", 0, 4'h5, 32'h00E300F0, 4'h1, 4'h1, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("rstmid", 0, 4'h5, 32'h00E300F0, 4'h1, 4'h1, 1, 4'h1, 0, 8'h00, 0, 0, 8'h0);
    add("rstmid", 0, 4'h4, 32'h00E30000, 4'h0, 4'h4, 1, 4'h0, 1, 8'hF0, 1, 1, 8'h0);
    add("rstmid", 0, 4'h4, 32'h00E30000, 4'h0, 4'h4, 1, 4'h4, 0, 8'h00, 0, 0, 8'h0);
    add("rstmid", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 1, 8'hE3, 0, 1, 8'h2);
    add("rstmid", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    // Granted source 1 stalls 5 cycles while source 3 requests; grant must hold.
    add("stall", 0, 4'h2, 32'h00006100, 4'h2, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);
    add("stall", 0, 4'h2, 32'h00006100, 4'h2, 4'h0, 1, 4'h2, 0, 8'h00, 0, 0, 8'h0);
    add("stall", 0, 4'h8, 32'h93006200, 4'h8, 4'h8, 1, 4'h2, 1, 8'h61, 1, 0, 8'h1);
    for (int i = 0; i < 4; i++) begin
      add("stall", 0, 4'h8, 32'h93006200, 4'h8, 4'h8, 1, 4'h2, 0, 8'h00, 0, 0, 8'h0);
    end
    add("stall", 0, 4'hA, 32'h93006200, 4'h8, 4'h8, 1, 4'h2, 0, 8'h00, 0, 0, 8'h0);
    add("stall", 0, 4'hA, 32'h93006300, 4'h8, 4'hA, 1, 4'h2, 1, 8'h62, 0, 0, 8'h1);
    add("stall", 0, 4'h8, 32'h93000000, 4'h8, 4'h8, 1, 4'h0, 1, 8'h63, 0, 1, 8'h1);
    add("stall", 0, 4'h8, 32'h93000000, 4'h8, 4'h8, 1, 4'h8, 0, 8'h00, 0, 0, 8'h0);
    add("stall", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 1, 8'h93, 1, 1, 8'h3);
    add("stall", 0, 4'h0, 32'h0,        4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 8'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset", -1, "in_ready",    32'(in_ready),          32'h0);
    chk("reset", -1, "out_valid",   32'(out_valid),         32'h0);
    chk("reset", -1, "out_data",    32'(out_data),          32'h0);
    chk("reset", -1, "out_sop",     32'(out_startofpacket), 32'h0);
    chk("reset", -1, "out_eop",     32'(out_endofpacket),   32'h0);
    chk("reset", -1, "out_channel", 32'(out_channel),       32'h0);

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      reset            = vecs[r].rst;
      in_valid         = vecs[r].iv;
      in_data          = vecs[r].dat;
      in_startofpacket = vecs[r].sop;
      in_endofpacket   = vecs[r].eop;
      out_ready        = vecs[r].ordy;
      #1;
      chk(vecs[r].name, r, "in_ready",  32'(in_ready),  32'(vecs[r].e_rdy));
      chk(vecs[r].name, r, "out_valid", 32'(out_valid), 32'(vecs[r].e_v));
      if (vecs[r].e_v) begin
        chk(vecs[r].name, r, "out_data",    32'(out_data),          32'(vecs[r].e_d));
        chk(vecs[r].name, r, "out_sop",     32'(out_startofpacket), 32'(vecs[r].e_s));
        chk(vecs[r].name, r, "out_eop",     32'(out_endofpacket),   32'(vecs[r].e_e));
        chk(vecs[r].name, r, "out_channel", 32'(out_channel),       32'(vecs[r].e_ch));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
